// File: rtl/fft16_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fft16_pkg
// Description : Shared definitions for the 16-point iterative radix-2 DIT FFT:
//               sizes and fixed-point formats, frame phase lengths, Q1.8
//               twiddle tables, the complex-sample type and bit reversal.
//               Optional feature macro used by the design: FFT_SATURATE_EN.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package fft16_pkg;

    localparam int N    = 16;       // transform size
    localparam int DW   = 17;       // Q8.8 sample part width
    localparam int TW   = 10;       // Q1.8 twiddle width
    localparam int FRAC = 8;        // fraction bits of the twiddles
    localparam int CW   = 2 * DW;   // packed complex width

    localparam int LOAD_LEN  = 16;
    localparam int CALC_LEN  = 32;
    localparam int OUT_LEN   = 16;
    localparam int FRAME_LEN = LOAD_LEN + CALC_LEN + OUT_LEN;

    typedef struct packed {
        logic signed [DW-1:0] re;
        logic signed [DW-1:0] im;
    } cplx_t;

    typedef enum logic [1:0] {
        PH_LOAD = 2'd0,
        PH_CALC = 2'd1,
        PH_OUT  = 2'd2
    } phase_t;

    // W^m = cos(2*pi*m/16) - j*sin(2*pi*m/16), scaled by 256
    localparam logic signed [TW-1:0] COS_TBL [8] = '{
        10'sd256, 10'sd237, 10'sd181, 10'sd98,
        10'sd0,  -10'sd98, -10'sd181, -10'sd237
    };
    localparam logic signed [TW-1:0] SIN_TBL [8] = '{
        10'sd0,   10'sd98,  10'sd181, 10'sd237,
        10'sd256, 10'sd237, 10'sd181, 10'sd98
    };

    function automatic logic [3:0] bitrev4(input logic [3:0] a);
        return {a[0], a[1], a[2], a[3]};
    endfunction

endpackage : fft16_pkg
`default_nettype wire

// File: rtl/fft16_butterfly.sv
`default_nettype none
// ============================================================================
// Module      : fft16_butterfly
// Description : Combinational radix-2 DIT butterfly: t = W*b, y_top = a + t,
//               y_bot = a - t. Products are floored (>>> 8) to 18 bits, the
//               add/sub is done in 18 bits and then reduced to 17 bits.
//               FFT_SATURATE_EN defined   : clamp to 0x0FFFF / 0x10000.
//               FFT_SATURATE_EN undefined : drop the top bit (wrap).
// Ports       : a, b          in  complex operands (Q8.8)
//               w_cos, w_sin  in  twiddle cos / sin (Q1.8)
//               y_top, y_bot  out butterfly results (Q8.8)
// Revision    : 1.0 - initial release
// ============================================================================
module fft16_butterfly
    import fft16_pkg::*;
(
    input  cplx_t                  a,
    input  cplx_t                  b,
    input  logic signed [TW-1:0]   w_cos,
    input  logic signed [TW-1:0]   w_sin,
    output cplx_t                  y_top,
    output cplx_t                  y_bot
);

    localparam int PW = DW + TW;    // single product width
    localparam int AW = DW + 1;     // add/sub width

`ifdef FFT_SATURATE_EN
    localparam logic signed [AW-1:0] SAT_MAX = AW'(2 ** (DW - 1) - 1);
    localparam logic signed [AW-1:0] SAT_MIN = AW'(-(2 ** (DW - 1)));
`endif

    function automatic logic [DW-1:0] reduce(input logic signed [AW-1:0] v);
`ifdef FFT_SATURATE_EN
        if (v > SAT_MAX) begin
            return DW'(SAT_MAX);
        end else if (v < SAT_MIN) begin
            return DW'(SAT_MIN);
        end
        return DW'(v);
`else
        return DW'(v);
`endif
    endfunction

    logic signed [PW-1:0] p_rc, p_is, p_ic, p_rs;
    logic signed [PW:0]   s_re, s_im;
    logic signed [AW-1:0] t_re, t_im, a_re, a_im;
    logic signed [AW-1:0] top_re, top_im, bot_re, bot_im;

    // (br + j*bi)(c - j*s) = (br*c + bi*s) + j(bi*c - br*s)
    assign p_rc = PW'($signed(b.re)) * PW'(w_cos);
    assign p_is = PW'($signed(b.im)) * PW'(w_sin);
    assign p_ic = PW'($signed(b.im)) * PW'(w_cos);
    assign p_rs = PW'($signed(b.re)) * PW'(w_sin);

    assign s_re = (PW + 1)'(p_rc) + (PW + 1)'(p_is);
    assign s_im = (PW + 1)'(p_ic) - (PW + 1)'(p_rs);

    // Floor toward -inf; the twiddle magnitudes keep the result inside 18 bits
    assign t_re = AW'(s_re >>> FRAC);
    assign t_im = AW'(s_im >>> FRAC);

    assign a_re = AW'($signed(a.re));
    assign a_im = AW'($signed(a.im));

    assign top_re = a_re + t_re;
    assign top_im = a_im + t_im;
    assign bot_re = a_re - t_re;
    assign bot_im = a_im - t_im;

    assign y_top.re = reduce(top_re);
    assign y_top.im = reduce(top_im);
    assign y_bot.re = reduce(bot_re);
    assign y_bot.im = reduce(bot_im);

endmodule : fft16_butterfly
`default_nettype wire

// File: rtl/fft16_iterative_core.sv
`default_nettype none
// ============================================================================
// Module      : fft16_iterative_core
// Description : Free-running 16-point radix-2 DIT FFT, 64-cycle frames:
//               LOAD (16) writes samples bit-reversed into a register RAM,
//               CALC (32) runs one in-place butterfly per cycle, OUT (16)
//               streams bins in natural order. Optional saturation of the
//               butterfly results via macro FFT_SATURATE_EN.
// Ports       : clk       in  clock, rising edge
//               rst_n     in  asynchronous active-low reset
//               data_in   in  complex sample {re[33:17], im[16:0]} Q8.8
//               data_out  out registered FFT bin, same format; 0 in
//                             LOAD/CALC
// Revision    : 1.0 - initial release
// ============================================================================
module fft16_iterative_core
    import fft16_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic [CW-1:0]   data_in,
    output logic [CW-1:0]   data_out
);

    localparam int CNT_W = $clog2(FRAME_LEN);
    localparam int AW    = $clog2(N);
    localparam int CI_W  = $clog2(CALC_LEN);

    localparam logic [CNT_W-1:0] CALC_START = CNT_W'(LOAD_LEN);
    localparam logic [CNT_W-1:0] OUT_START  = CNT_W'(LOAD_LEN + CALC_LEN);

    logic [CNT_W-1:0] cnt;
    phase_t           phase;
    logic [CW-1:0]    ram [N];

    logic [CI_W-1:0]  calc_idx;
    logic [1:0]       stage;
    logic [2:0]       bfly;
    logic [AW-1:0]    span, j_idx, top_addr, bot_addr;
    logic [2:0]       tw_idx;
    cplx_t            bf_a, bf_b, bf_top, bf_bot;

    // Phase decode from the frame counter
    always_comb begin
        phase = PH_LOAD;
        if (cnt >= OUT_START) begin
            phase = PH_OUT;
        end else if (cnt >= CALC_START) begin
            phase = PH_CALC;
        end
    end

    // Butterfly addressing: calc index is stage-major {stage, butterfly}
    assign calc_idx = CI_W'(cnt - CALC_START);
    assign stage    = calc_idx[4:3];
    assign bfly     = calc_idx[2:0];

    always_comb begin
        span     = AW'(1) << stage;
        j_idx    = {1'b0, bfly} & (span - AW'(1));
        top_addr = (({1'b0, bfly} >> stage) << ({1'b0, stage} + 3'd1)) | j_idx;
        bot_addr = top_addr + span;
        tw_idx   = 3'(j_idx << (2'd3 - stage));
    end

    assign bf_a = ram[top_addr];
    assign bf_b = ram[bot_addr];

    fft16_butterfly u_butterfly (
        .a     (bf_a),
        .b     (bf_b),
        .w_cos (COS_TBL[tw_idx]),
        .w_sin (SIN_TBL[tw_idx]),
        .y_top (bf_top),
        .y_bot (bf_bot)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            data_out <= '0;
            for (int i = 0; i < N; i++) begin
                ram[i] <= '0;
            end
        end else begin
            // Counter wraps naturally at the 64-cycle frame boundary
            cnt      <= cnt + CNT_W'(1);
            data_out <= '0;
            case (phase)
                PH_LOAD: ram[bitrev4(cnt[AW-1:0])] <= data_in;
                PH_CALC: begin
                    ram[top_addr] <= bf_top;
                    ram[bot_addr] <= bf_bot;
                end
                PH_OUT:  data_out <= ram[cnt[AW-1:0]];
                default: ;
            endcase
        end
    end

endmodule : fft16_iterative_core
`default_nettype wire

// File: tb/tb_fft16_iterative_core.sv
`default_nettype none
// ============================================================================
// Module      : tb_fft16_iterative_core
// Description : Self-checking bench for fft16_iterative_core. A reference
//               DFT (radix-2 with the fixed-point rules, plain integers)
//               produces the expected bins per frame; a negedge compare
//               process checks data_out every cycle. Directed frames:
//               impulse, DC, shifted impulse, overflow, random, plus resets
//               in CALC and OUT. Honours FFT_SATURATE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fft16_iterative_core;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [33:0] data_in = '0;
    logic [33:0] data_out;

    int checks = 0;
    int errors = 0;
    int edge_n = -1;            // index of last rising edge since reset release
    bit compare_en = 1'b0;

    logic [33:0] in_frames  [8][16];
    logic [33:0] exp_frames [8][16];

    int COS_M [8] = '{256, 237, 181, 98, 0, -98, -181, -237};
    int SIN_M [8] = '{0, 98, 181, 237, 256, 237, 181, 98};

    always #5 clk = ~clk;

    fft16_iterative_core dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .data_in  (data_in),
        .data_out (data_out)
    );

    always @(posedge clk) edge_n <= rst_n ? edge_n + 1 : -1;

    task automatic check(input string name, input logic [33:0] act, input logic [33:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    function automatic int s17(input logic [16:0] v);
        logic signed [16:0] t;
        t = v;
        return int'(t);
    endfunction

    // 18-bit add/sub result reduced to the 17-bit output range
    function automatic int fit17(input int v);
        logic signed [17:0] v18;
        logic signed [16:0] v17;
        int w;
        v18 = v[17:0];
        w = int'(v18);
`ifdef FFT_SATURATE_EN
        v17 = '0;
        if (w > 65535) w = 65535;
        else if (w < -65536) w = -65536;
`else
        v17 = v18[16:0];
        w = int'(v17);
`endif
        return w;
    endfunction

    function automatic int bitrev(input int i);
        int r = 0;
        for (int k = 0; k < 4; k++) if (((i >> k) & 1) != 0) r |= (1 << (3 - k));
        return r;
    endfunction

    task automatic compute_expected(input int f);
        int re [16];
        int im [16];
        int m, tp, bt, tr, ti, ar, ai;
        for (int i = 0; i < 16; i++) begin
            re[bitrev(i)] = s17(in_frames[f][i][33:17]);
            im[bitrev(i)] = s17(in_frames[f][i][16:0]);
        end
        for (int half = 1; half < 16; half *= 2) begin
            for (int g = 0; g < 16; g += 2 * half) begin
                for (int j = 0; j < half; j++) begin
                    m  = j * (8 / half);
                    tp = g + j;
                    bt = tp + half;
                    tr = (re[bt] * COS_M[m] + im[bt] * SIN_M[m]) >>> 8;
                    ti = (im[bt] * COS_M[m] - re[bt] * SIN_M[m]) >>> 8;
                    ar = re[tp];
                    ai = im[tp];
                    re[tp] = fit17(ar + tr);
                    im[tp] = fit17(ai + ti);
                    re[bt] = fit17(ar - tr);
                    im[bt] = fit17(ai - ti);
                end
            end
        end
        for (int k = 0; k < 16; k++) exp_frames[f][k] = {17'(re[k]), 17'(im[k])};
    endtask

    // Every cycle: bin k after edge 48+k of a frame, zero otherwise
    logic [33:0] cmp_exp;
    int cmp_pos, cmp_fr;
    always @(negedge clk) begin
        if (compare_en) begin
            cmp_exp = '0;
            if (rst_n && edge_n >= 0) begin
                cmp_pos = edge_n % 64;
                cmp_fr  = edge_n / 64;
                if (cmp_pos >= 48 && cmp_fr < 8) cmp_exp = exp_frames[cmp_fr][cmp_pos - 48];
            end
            check($sformatf("data_out edge %0d", edge_n), data_out, cmp_exp);
        end
    end

    // Drive n edges starting from just after a negedge; inputs outside
    // LOAD are random to show they are ignored.
    task automatic drive_edges(input int n);
        int e, pos, fr;
        logic [63:0] rnd;
        for (int k = 0; k < n; k++) begin
            e   = edge_n + 1;
            pos = e % 64;
            fr  = e / 64;
            rnd = {$urandom(), $urandom()};
            data_in = (pos < 16 && fr < 8) ? in_frames[fr][pos] : rnd[33:0];
            @(negedge clk);
            #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not end in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int r;
        logic [63:0] rnd;
        for (int f = 0; f < 8; f++)
            for (int i = 0; i < 16; i++) begin
                in_frames[f][i]  = '0;
                exp_frames[f][i] = '0;
            end
        in_frames[0][0] = {17'h00100, 17'h00000};                  // impulse
        for (int i = 0; i < 16; i++) in_frames[1][i] = {17'h00100, 17'h00000}; // DC
        in_frames[2][1] = {17'h00100, 17'h00000};                  // shifted impulse
        for (int i = 0; i < 16; i++) in_frames[3][i] = {17'h0C800, 17'h00000}; // overflow
        for (int i = 0; i < 16; i++) begin                         // random +-8.0
            r = int'($urandom_range(4095)) - 2048;
            in_frames[4][i][33:17] = 17'(r);
            r = int'($urandom_range(4095)) - 2048;
            in_frames[4][i][16:0] = 17'(r);
        end
        for (int i = 0; i < 16; i++) begin                         // discarded by reset
            rnd = {$urandom(), $urandom()};
            in_frames[5][i] = rnd[33:0];
        end
        for (int f = 0; f < 5; f++) compute_expected(f);

        // Hand-computed values pinning the reference model
        check("model impulse X5", exp_frames[0][5], {17'h00100, 17'h00000});
        check("model impulse X15", exp_frames[0][15], {17'h00100, 17'h00000});
        check("model DC X0", exp_frames[1][0], {17'h01000, 17'h00000});
        check("model DC X7", exp_frames[1][7], 34'h0);
        check("model shift X0", exp_frames[2][0], {17'h00100, 17'h00000});
        check("model shift X2", exp_frames[2][2], {17'h000B5, 17'h1FF4B});
        check("model shift X4", exp_frames[2][4], {17'h00000, 17'h1FF00});
        check("model shift X8", exp_frames[2][8], {17'h1FF00, 17'h00000});
`ifdef FFT_SATURATE_EN
        check("model overflow X0", exp_frames[3][0], {17'h0FFFF, 17'h00000});
`else
        check("model overflow X0", exp_frames[3][0], {17'h08000, 17'h00000});
`endif
        check("model overflow X9", exp_frames[3][9], 34'h0);

        repeat (3) @(negedge clk);
        check("reset state", data_out, 34'h0);
        #1;
        compare_en = 1'b1;
        rst_n = 1'b1;

        // Frames 0..4 back to back, frame 5 cut by reset after its E30
        drive_edges(5 * 64 + 31);
        rst_n = 1'b0;
        #1;
        check("async reset in CALC", data_out, 34'h0);
        repeat (2) @(negedge clk);
        #1;
        rst_n = 1'b1;

        // Impulse, DC, then reset while shifted-impulse bins are streaming
        drive_edges(2 * 64 + 53);
        rst_n = 1'b0;
        #1;
        check("async reset in OUT", data_out, 34'h0);
        repeat (2) @(negedge clk);
        #1;
        rst_n = 1'b1;

        // Clean impulse frame after reset
        drive_edges(64);
        compare_en = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_fft16_iterative_core
`default_nettype wire
